topcell_pattern_sequencer: RTL and testbench
============================================

Name: topcell_pattern_sequencer

Overview:
- Sequencer that drives stimulus into the TopCell combinational netlist and compacts its responses.
- Applies N patterns to TopCell `data[7:0]`, waits a programmable settle time, then samples `out1..out5`.
- Folds each sample into a 16-bit MISR signature and reports `busy`/`done`.
- Sits between the test/config logic and TopCell. TopCell is instantiated outside this block.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after applying a pattern before capture (legal range 1..15).
- SIG_SEED, 16'hFFFF, value loaded into the MISR on start.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; sampled only in IDLE.
- abort  input  1  terminates a run; returns to IDLE on the next edge.
- mode  input  1  0 = exhaustive counter patterns, 1 = LFSR patterns; latched on start.
- pattern_count  input  9  number of patterns, 0..256; latched on start.
- dut_resp  input  5  {out5,out4,out3,out2,out1} from TopCell.
- dut_data  output  8  drives TopCell `data[7:0]`.
- busy  output  1  high in APPLY, SETTLE and CAPTURE.
- done  output  1  one-cycle pulse in DONE.
- signature  output  16  MISR value; stable whenever not busy.
- pattern_idx  output  9  number of patterns captured so far in the current run.

Behaviour:
- Reset values: dut_data=0, busy=0, done=0, signature=16'h0000, pattern_idx=0, state=IDLE, settle counter=0, LFSR=8'h01.
- States: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE, start=1 at edge t:
  - Latch mode and pattern_count; load signature=SIG_SEED; set pattern_idx=0.
  - pattern_count=0: go to DONE.
  - Otherwise: go to APPLY, and set dut_data=first pattern at edge t.
- Pattern source:
  - mode 0: dut_data = pattern_idx[7:0], so the sequence is 0,1,2,...
  - mode 1: LFSR starting at 8'h01; next = {p[6:0], p[7]^p[5]^p[4]^p[3]}. Period is 255.
- APPLY (1 cycle): dut_data holds the pattern; go to SETTLE and clear the settle counter.
- SETTLE: count to SETTLE_CYCLES, then go to CAPTURE. dut_data holds throughout.
- CAPTURE (1 cycle):
  - Update signature: sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {11'b0, dut_resp}.
  - Increment pattern_idx.
  - If pattern_idx+1 == latched count: go to DONE.
  - Otherwise: advance the pattern (counter+1 or LFSR step), update dut_data, go to APPLY.
- Timing:
  - Each pattern takes SETTLE_CYCLES+2 cycles.
  - busy stays high for N*(SETTLE_CYCLES+2) cycles.
  - done rises on the cycle after the last CAPTURE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. signature and pattern_idx hold until the next start.
- Boundary and concurrency rules:
  - start while busy or in DONE: ignored.
  - Changes to mode/pattern_count mid-run have no effect.
  - abort in any non-IDLE state: next state IDLE, busy=0, no done pulse; signature and pattern_idx keep their partial values; dut_data holds.
  - abort and start asserted together in IDLE: start is ignored.
  - pattern_count=256 in mode 0 covers 0..255 with no wrap error; pattern_idx reaches 256.
  - pattern_count=256 in mode 1 repeats pattern 8'h01 at index 255.
  - pattern_count > 256: saturated to 256.
- rst asserted mid-run: everything returns to reset values immediately (asynchronous); no done pulse.

Test Plan:
1. Single pattern: SETTLE_CYCLES=2, mode 0, count=1, dut_resp tied to 5'h00 → dut_data=0 through SETTLE; done 4 cycles after busy rises; signature=16'hEFDF; pattern_idx=1.
2. Zero count: start with pattern_count=0 → no busy; done pulses the cycle after start; signature=16'hFFFF; pattern_idx=0.
3. Exhaustive run: mode 0, count=256, bench computes responses from a TopCell reference model → dut_data steps 0..255; busy lasts 1024 cycles; final signature matches the model MISR.
4. LFSR sequence: mode 1, count=4 → dut_data sequence 01, 02, 04, 08; pattern_idx=4; done single-cycle.
5. Abort: abort asserted during SETTLE of pattern 3 (count=10) → IDLE next edge, busy=0, no done pulse, pattern_idx=2; a new start reseeds signature to FFFF and runs normally.
6. Async reset: rst pulsed between clock edges mid-CAPTURE → all outputs at reset values before the next edge; start ignored while busy (checked earlier in the same run).

Source files
------------

// File: rtl/topcell_pattern_sequencer_if.sv
// Config/response bundle between the test logic, TopCell and the pattern sequencer.
// The sequencer takes the slave side; the environment takes the master side.
interface topcell_pattern_sequencer_if;
    logic        start;
    logic        abort;
    logic        mode;
    logic [8:0]  pattern_count;
    logic [4:0]  dut_resp;
    logic [7:0]  dut_data;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [8:0]  pattern_idx;

    modport master (
        output start, abort, mode, pattern_count, dut_resp,
        input  dut_data, busy, done, signature, pattern_idx
    );

    modport slave (
        input  start, abort, mode, pattern_count, dut_resp,
        output dut_data, busy, done, signature, pattern_idx
    );
endinterface

// File: rtl/topcell_pattern_sequencer.sv
// Applies counter or LFSR patterns to TopCell, waits a settle time, and folds
// each 5-bit response into a 16-bit MISR signature.
module topcell_pattern_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [15:0] SIG_SEED      = 16'hFFFF
) (
    input logic                         clk,
    input logic                         rst,
    topcell_pattern_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        mode_q, mode_d;
    logic [8:0]  count_q, count_d;
    logic [15:0] sig_q, sig_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic [3:0]  settle_q, settle_d;

    logic [15:0] sig_next;
    logic [8:0]  idx_inc;
    logic [7:0]  lfsr_next;
    logic [8:0]  count_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            count_q  <= 9'd0;
            sig_q    <= 16'h0000;
            idx_q    <= 9'd0;
            data_q   <= 8'h00;
            lfsr_q   <= 8'h01;
            settle_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            count_q  <= count_d;
            sig_q    <= sig_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            lfsr_q   <= lfsr_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        count_d  = count_q;
        sig_d    = sig_q;
        idx_d    = idx_q;
        data_d   = data_q;
        lfsr_d   = lfsr_q;
        settle_d = settle_q;

        sig_next  = {sig_q[14:0], 1'b0}
                  ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                  ^ {11'b0, bus.dut_resp};
        idx_inc   = idx_q + 9'd1;
        lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        count_sat = (bus.pattern_count > 9'd256) ? 9'd256 : bus.pattern_count;

        // Abort wins over everything, leaving partial results visible.
        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        mode_d  = bus.mode;
                        count_d = count_sat;
                        sig_d   = SIG_SEED;
                        idx_d   = 9'd0;
                        lfsr_d  = 8'h01;
                        if (count_sat == 9'd0) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_APPLY;
                            data_d  = bus.mode ? 8'h01 : 8'h00;
                        end
                    end
                end
                S_APPLY: begin
                    state_d  = S_SETTLE;
                    settle_d = 4'd0;
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = S_CAPTURE;
                    end else begin
                        settle_d = settle_q + 4'd1;
                    end
                end
                S_CAPTURE: begin
                    sig_d = sig_next;
                    idx_d = idx_inc;
                    if (idx_inc == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_APPLY;
                        if (mode_q) begin
                            lfsr_d = lfsr_next;
                            data_d = lfsr_next;
                        end else begin
                            data_d = idx_inc[7:0];
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign bus.dut_data    = data_q;
    assign bus.busy        = (state_q == S_APPLY) || (state_q == S_SETTLE)
                          || (state_q == S_CAPTURE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.signature   = sig_q;
    assign bus.pattern_idx = idx_q;

endmodule

// File: tb/tb_topcell_pattern_sequencer.sv
// Bench for topcell_pattern_sequencer: table vectors, randomized runs against a
// pattern-list/MISR reference model, and hand-written abort and reset sequences.
module tb_topcell_pattern_sequencer;

    localparam int S   = 2;
    localparam int PER = S + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    topcell_pattern_sequencer_if ifc();

    topcell_pattern_sequencer #(
        .SETTLE_CYCLES(S),
        .SIG_SEED(16'hFFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    bit         tie = 1'b1;
    logic [7:0] key = 8'h00;
    logic [7:0] pats [256];

    // Stand-in for the TopCell netlist: an arbitrary fixed boolean function.
    function automatic logic [4:0] topcell(input logic [7:0] d);
        return {d > 8'd100, d[2] ^ d[5], d[7] | d[0], &d[3:0], ^d};
    endfunction

    assign ifc.dut_resp = tie ? 5'h00 : topcell(ifc.dut_data ^ key);

    function automatic logic [7:0] lfsr_step(input logic [7:0] p);
        return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
    endfunction

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [4:0] r);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {11'b0, r};
    endfunction

    task automatic model(input bit m, input int n, input bit t,
                         input logic [7:0] k, output logic [15:0] sig);
        logic [7:0] p;
        p   = 8'h01;
        sig = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            pats[i] = m ? p : 8'(i);
            p       = lfsr_step(p);
            sig     = misr(sig, t ? 5'h00 : topcell(pats[i] ^ k));
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input bit m, input int cnt, input bit t,
                       input logic [7:0] k, input bit poke,
                       input bit use_const, input logic [15:0] csig,
                       input string tag);
        int         n;
        int         busy_c;
        int         done_c;
        int         done_at;
        int         derr;
        int         cyc;
        bit         seen_done;
        bit         seed_ok;
        logic [15:0] esig;
        n         = (cnt > 256) ? 256 : cnt;
        busy_c    = 0;
        done_c    = 0;
        done_at   = -1;
        derr      = 0;
        cyc       = 0;
        seen_done = 1'b0;
        seed_ok   = 1'b1;
        tie       = t;
        key       = k;
        model(m, n, t, k, esig);
        if (use_const) esig = csig;
        @(negedge clk);
        ifc.mode          = m;
        ifc.pattern_count = 9'(cnt);
        ifc.start         = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        while (cyc < 3000) begin
            if (ifc.busy) begin
                if (busy_c == 0 && ifc.signature !== 16'hFFFF) seed_ok = 1'b0;
                if (ifc.dut_data !== pats[busy_c / PER]) derr++;
                busy_c++;
            end
            if (ifc.done) begin
                done_c++;
                if (!seen_done) done_at = busy_c;
                seen_done = 1'b1;
            end else if (seen_done) begin
                break;
            end
            if (poke && busy_c == PER + 1) begin
                ifc.start         = 1'b1;
                ifc.mode          = ~m;
                ifc.pattern_count = 9'($urandom_range(0, 511));
            end else begin
                ifc.start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        ifc.start = 1'b0;
        check({tag, " completed"}, {31'b0, seen_done && cyc < 3000}, 32'd1);
        check({tag, " busy_cycles"}, busy_c, n * PER);
        check({tag, " done_pulses"}, done_c, 32'd1);
        check({tag, " done_position"}, done_at, n * PER);
        check({tag, " data_errors"}, derr, 32'd0);
        if (n > 0) check({tag, " seed"}, {31'b0, seed_ok}, 32'd1);
        check({tag, " signature"}, ifc.signature, esig);
        check({tag, " pattern_idx"}, ifc.pattern_idx, n);
        check({tag, " busy_after"}, ifc.busy, 32'd0);
    endtask

    typedef struct {
        bit         m;
        int         cnt;
        bit         t;
        bit         use_const;
        logic [15:0] csig;
        bit         chk_last;
        logic [7:0] last;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [15:0] esig_abort;
        logic [8:0]  idx_save;
        int          bc;
        int          dcount;

        vecs[0] = '{0, 1,   1, 1, 16'hEFDF, 1, 8'h00};
        vecs[1] = '{0, 0,   1, 1, 16'hFFFF, 0, 8'h00};
        vecs[2] = '{0, 2,   1, 1, 16'hCF9F, 1, 8'h01};
        vecs[3] = '{1, 4,   1, 1, 16'h0E1F, 1, 8'h08};
        vecs[4] = '{0, 256, 0, 0, 16'h0000, 1, 8'hFF};
        vecs[5] = '{1, 256, 0, 0, 16'h0000, 1, 8'h01};
        vecs[6] = '{0, 300, 0, 0, 16'h0000, 1, 8'hFF};
        vecs[7] = '{1, 3,   0, 0, 16'h0000, 1, 8'h04};

        ifc.start         = 1'b0;
        ifc.abort         = 1'b0;
        ifc.mode          = 1'b0;
        ifc.pattern_count = 9'd0;

        rst = 1'b1;
        @(negedge clk);
        check("reset dut_data", ifc.dut_data, 32'h0);
        check("reset busy", ifc.busy, 32'h0);
        check("reset done", ifc.done, 32'h0);
        check("reset signature", ifc.signature, 32'h0);
        check("reset pattern_idx", ifc.pattern_idx, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run(vecs[i].m, vecs[i].cnt, vecs[i].t, 8'($urandom), 1'b0,
                vecs[i].use_const, vecs[i].csig, $sformatf("vec%0d", i));
            if (vecs[i].chk_last)
                check($sformatf("vec%0d last_data", i), ifc.dut_data, vecs[i].last);
        end

        // abort together with start in IDLE must not launch a run
        idx_save = ifc.pattern_idx;
        @(negedge clk);
        ifc.abort         = 1'b1;
        ifc.start         = 1'b1;
        ifc.pattern_count = 9'd5;
        @(negedge clk);
        ifc.abort = 1'b0;
        ifc.start = 1'b0;
        check("abort_start busy", ifc.busy, 32'h0);
        check("abort_start done", ifc.done, 32'h0);
        check("abort_start idx", ifc.pattern_idx, idx_save);

        // abort during SETTLE of the third pattern
        tie = 1'b0;
        key = 8'h5A;
        model(1'b0, 2, 1'b0, 8'h5A, esig_abort);
        @(negedge clk);
        ifc.mode          = 1'b0;
        ifc.pattern_count = 9'd10;
        ifc.start         = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        bc = 0;
        for (int g = 0; g < 100 && bc < 10; g++) begin
            if (ifc.busy) bc++;
            if (bc < 10) @(negedge clk);
        end
        check("abort reach_settle", bc, 32'd10);
        ifc.abort = 1'b1;
        @(negedge clk);
        ifc.abort = 1'b0;
        check("abort busy", ifc.busy, 32'h0);
        check("abort done", ifc.done, 32'h0);
        check("abort pattern_idx", ifc.pattern_idx, 32'd2);
        check("abort signature", ifc.signature, esig_abort);
        check("abort dut_data", ifc.dut_data, 32'h02);
        dcount = 0;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            if (ifc.done || ifc.busy) dcount++;
        end
        check("abort quiet", dcount, 32'd0);
        run(1'b0, 7, 1'b0, 8'h33, 1'b0, 1'b0, 16'h0, "post_abort");

        for (int r = 0; r < 6; r++) begin
            run(1'($urandom_range(0, 1)), $urandom_range(1, 60), 1'b0,
                8'($urandom), 1'b1, 1'b0, 16'h0, $sformatf("rnd%0d", r));
        end

        // asynchronous reset in the middle of a CAPTURE cycle
        tie = 1'b0;
        key = 8'hC3;
        @(negedge clk);
        ifc.mode          = 1'b1;
        ifc.pattern_count = 9'd5;
        ifc.start         = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        bc = 0;
        for (int g = 0; g < 100 && bc < 8; g++) begin
            if (ifc.busy) bc++;
            ifc.start = (bc == 3);
            if (ifc.start) ifc.pattern_count = 9'd0;
            if (bc < 8) @(negedge clk);
        end
        ifc.start = 1'b0;
        check("rst reach_capture", bc, 32'd8);
        check("rst busy_before", ifc.busy, 32'h1);
        check("rst idx_before", ifc.pattern_idx, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst dut_data", ifc.dut_data, 32'h0);
        check("rst busy", ifc.busy, 32'h0);
        check("rst done", ifc.done, 32'h0);
        check("rst signature", ifc.signature, 32'h0);
        check("rst pattern_idx", ifc.pattern_idx, 32'h0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst no_done", {31'b0, ifc.done | ifc.busy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
